// File: rtl/branch_resolve_unit.sv
// Branch resolution stage: evaluates conditional branches and jumps, produces the
// redirect target, and trains a 2-bit bimodal predictor on resolved conditionals.
module branch_resolve_unit #(
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            BRUInValid,
  output logic            BRUInReady,
  input  logic [XLEN-1:0] BRURs1,
  input  logic [XLEN-1:0] BRURs2,
  input  logic [XLEN-1:0] BRUPC,
  input  logic [XLEN-1:0] BRUImm,
  input  logic [4:0]      BRUBrOp,
  input  logic            BRUPredTakenIn,
  input  logic [XLEN-1:0] BRUQueryPC,
  output logic            BRUPredTaken,
  output logic            BRUOutValid,
  input  logic            BRUOutReady,
  output logic            BRUNextPCSrc,
  output logic [XLEN-1:0] BRUNextPC,
  output logic [XLEN-1:0] BRULink,
  output logic            BRUMispredict,
  output logic [31:0]     BRUMispredCount
);

  localparam int IDX = $clog2(BHT_DEPTH);

  typedef enum logic [4:0] {
    OP_BEQ  = 5'b00000,
    OP_BNE  = 5'b00001,
    OP_BLT  = 5'b00100,
    OP_BGE  = 5'b00101,
    OP_BLTU = 5'b00110,
    OP_BGEU = 5'b00111,
    OP_JAL  = 5'b01111,
    OP_JALR = 5'b10111
  } br_op_e;

  logic [1:0]      bht [BHT_DEPTH];
  br_op_e          op;
  logic            is_cond;
  logic            is_jump;
  logic            is_jalr;
  logic            cond_true;
  logic            taken;
  logic            mispredict;
  logic            accept;
  logic [XLEN-1:0] pc_plus_imm;
  logic [XLEN-1:0] rs1_plus_imm;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] link;
  logic [IDX-1:0]  upd_idx;
  logic [1:0]      ctr_next;
  logic            unused_query_bits;

  assign op           = br_op_e'(BRUBrOp);
  assign pc_plus_imm  = BRUPC + BRUImm;
  assign rs1_plus_imm = BRURs1 + BRUImm;
  assign link         = BRUPC + XLEN'(4);
  assign upd_idx      = BRUPC[IDX+1:2];

  // NOTE: every signal driven here gets a default before the case, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    is_cond   = 1'b0;
    is_jump   = 1'b0;
    is_jalr   = 1'b0;
    cond_true = 1'b0;
    case (op)
      OP_BEQ:  begin is_cond = 1'b1; cond_true = (BRURs1 == BRURs2); end
      OP_BNE:  begin is_cond = 1'b1; cond_true = (BRURs1 != BRURs2); end
      OP_BLT:  begin is_cond = 1'b1; cond_true = ($signed(BRURs1) <  $signed(BRURs2)); end
      OP_BGE:  begin is_cond = 1'b1; cond_true = ($signed(BRURs1) >= $signed(BRURs2)); end
      OP_BLTU: begin is_cond = 1'b1; cond_true = (BRURs1 <  BRURs2); end
      OP_BGEU: begin is_cond = 1'b1; cond_true = (BRURs1 >= BRURs2); end
      OP_JAL:  is_jump = 1'b1;
      OP_JALR: begin is_jump = 1'b1; is_jalr = 1'b1; end
      default: ;
    endcase
  end

  assign taken      = is_jump | (is_cond & cond_true);
  assign target     = is_jalr ? {rs1_plus_imm[XLEN-1:1], 1'b0} : pc_plus_imm;
  assign mispredict = (taken != BRUPredTakenIn);

  assign BRUInReady = !BRUOutValid | BRUOutReady;
  assign accept     = BRUInValid & BRUInReady;

  // Saturating update of the counter addressed by the request PC.
  always_comb begin
    ctr_next = bht[upd_idx];
    if (taken) begin
      if (bht[upd_idx] != 2'b11) ctr_next = bht[upd_idx] + 2'd1;
    end else begin
      if (bht[upd_idx] != 2'b00) ctr_next = bht[upd_idx] - 2'd1;
    end
  end

  // The array is read before the edge, so a same-edge update is not yet visible.
  assign BRUPredTaken      = bht[BRUQueryPC[IDX+1:2]][1];
  assign unused_query_bits = ^{BRUQueryPC[XLEN-1:IDX+2], BRUQueryPC[1:0]};

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      BRUOutValid     <= 1'b0;
      BRUNextPCSrc    <= 1'b0;
      BRUNextPC       <= '0;
      BRULink         <= '0;
      BRUMispredict   <= 1'b0;
      BRUMispredCount <= '0;
      // NOTE: the predictor array is reset because weakly-not-taken is an
      // architectural starting point, not a don't-care.
      for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= 2'b01;
    end else begin
      if (accept) begin
        BRUOutValid   <= 1'b1;
        BRUNextPCSrc  <= taken;
        BRUNextPC     <= taken ? target : link;
        BRULink       <= link;
        BRUMispredict <= mispredict;
      end else if (BRUOutReady) begin
        BRUOutValid <= 1'b0;
      end
      if (accept && mispredict) BRUMispredCount <= BRUMispredCount + 32'd1;
      if (accept && is_cond) bht[upd_idx] <= ctr_next;
    end
  end

endmodule
